// File: rtl/riscv_fetch_pkg.sv
// -----------------------------------------------------------------------------
// riscv_fetch_pkg
// Shared types and helpers for the instruction fetch stage.
//   fetch_entry_t     : one buffered fetch result {pc, inst, fault}
//   FETCH_BOOT_VECTOR : default PC of the first fetch after reset
//   pc_next()         : sequential PC step, wraps silently at 2^32
// -----------------------------------------------------------------------------
package riscv_fetch_pkg;

    localparam logic [31:0] FETCH_BOOT_VECTOR = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_entry_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/riscv_fetch_if.sv
// -----------------------------------------------------------------------------
// riscv_fetch_if
// Instruction cache / memory port seen by the fetch stage.
//   rd     : read request valid                 (fetch -> memory)
//   pc     : word-aligned read address          (fetch -> memory)
//   accept : request accepted this cycle        (memory -> fetch)
//   valid  : in-order response valid           (memory -> fetch)
//   inst   : response instruction word          (memory -> fetch)
//   error  : response bus error                 (memory -> fetch)
// master = fetch stage, slave = cache/memory.
// -----------------------------------------------------------------------------
interface riscv_fetch_if;

    logic        rd;
    logic [31:0] pc;
    logic        accept;
    logic        valid;
    logic [31:0] inst;
    logic        error;

    modport master (
        output rd, pc,
        input  accept, valid, inst, error
    );

    modport slave (
        input  rd, pc,
        output accept, valid, inst, error
    );

endinterface

// File: rtl/riscv_fetch_fifo.sv
// -----------------------------------------------------------------------------
// riscv_fetch_fifo
// Small FIFO of fetch results with a combinational head.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   push, data_in: write an entry (accepted when not full, or when popping)
//   pop, data_out: head entry, removed on pop when not empty
//   flush        : discard all entries (wins over push/pop)
//   count, empty, full : occupancy status
// DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module riscv_fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           data_in,
    output fetch_entry_t           data_out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    fetch_entry_t mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (count == (AW + 1)'(DEPTH));
    assign data_out = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: storage is reset as well because the head entry drives module
    // outputs directly; unreset storage would leak X onto them after reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_in;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // The fetch credit scheme must never push into a full buffer.
    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rst_i) !(push && full && !pop)
    );

endmodule

// File: rtl/riscv_fetch.sv
// -----------------------------------------------------------------------------
// riscv_fetch
// In-order instruction fetch stage: issues reads on the icache port, buffers
// returned words in a small FIFO and presents {opcode, pc, valid} to decode.
//   clk_i, rst_i       : clock, asynchronous active-low reset
//   icache (master)    : read request/response port, see riscv_fetch_if
//   opcode_o           : instruction at FIFO head
//   opcode_pc_o        : PC of opcode_o
//   opcode_valid_o     : head valid (forced low while branch_i is high)
//   fault_fetch_o      : head entry returned a bus error
//   branch_i/branch_pc_i : redirect request and target
//   stall_i            : consumer cannot take the head this cycle
// Build option RISCV_FETCH_FAULT_EN: when defined, icache error is stored per
// entry and reported on fault_fetch_o; otherwise fault_fetch_o is tied low.
// -----------------------------------------------------------------------------
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_VECTOR     = FETCH_BOOT_VECTOR,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2   // must be <= FIFO_DEPTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    riscv_fetch_if.master        icache,
    output logic [31:0]          opcode_o,
    output logic [31:0]          opcode_pc_o,
    output logic                 opcode_valid_o,
    output logic                 fault_fetch_o,
    input  logic                 branch_i,
    input  logic [31:0]          branch_pc_i,
    input  logic                 stall_i
);

    // Counters are as wide as the FIFO count; MAX_OUTSTANDING <= FIFO_DEPTH.
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [31:0]   pc_q;
    logic [31:0]   resp_pc_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] outstanding_d;
    logic [CW-1:0] discard_q;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   inflight;
    logic          fifo_empty;
    logic          fifo_full_unused;
    logic          req_fire;
    logic          fifo_push;
    logic          fifo_pop;
    logic [31:0]   branch_target;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // Credits: a read is only issued when its word is guaranteed a FIFO slot.
    assign inflight  = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign icache.rd = rst_i && !branch_i
                     && (inflight < (CW + 1)'(FIFO_DEPTH))
                     && (outstanding_q < CW'(MAX_OUTSTANDING));
    assign icache.pc = pc_q;
    assign req_fire  = icache.rd && icache.accept;

    assign branch_target = {branch_pc_i[31:2], 2'b00};

    // Responses owed to a flushed stream are dropped while discard_q drains.
    assign fifo_push = icache.valid && !branch_i && (discard_q == '0);

    assign opcode_valid_o = !fifo_empty && !branch_i;
    assign fifo_pop       = opcode_valid_o && !stall_i;
    assign opcode_o       = head_entry.inst;
    assign opcode_pc_o    = head_entry.pc;

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = resp_pc_q;
        push_entry.inst = icache.inst;
`ifdef RISCV_FETCH_FAULT_EN
        push_entry.fault = icache.error;
`endif
    end

`ifdef RISCV_FETCH_FAULT_EN
    assign fault_fetch_o = head_entry.fault && opcode_valid_o;
`else
    logic unused_fault;
    assign unused_fault  = icache.error ^ head_entry.fault;
    assign fault_fetch_o = 1'b0;
`endif

    // NOTE: outstanding_d is given its default before any condition so the
    // block stays purely combinational and infers no latch.
    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire && !icache.valid) begin
            outstanding_d = outstanding_q + CNT_ONE;
        end else if (!req_fire && icache.valid) begin
            outstanding_d = outstanding_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q          <= BOOT_VECTOR;
            resp_pc_q     <= BOOT_VECTOR;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (branch_i) begin
                // No request fires on a branch cycle, so every read still in
                // flight after this edge belongs to the old stream.
                pc_q      <= branch_target;
                resp_pc_q <= branch_target;
                discard_q <= outstanding_d;
            end else begin
                if (req_fire) begin
                    pc_q <= pc_next(pc_q);
                end
                if (icache.valid) begin
                    if (discard_q != '0) begin
                        discard_q <= discard_q - CNT_ONE;
                    end else begin
                        resp_pc_q <= pc_next(resp_pc_q);
                    end
                end
            end
        end
    end

    riscv_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (branch_i),
        .data_in  (push_entry),
        .data_out (head_entry),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full_unused)
    );

    // A response without a matching accepted request breaks PC tracking.
    a_resp_has_request: assert property (
        @(posedge clk_i) disable iff (!rst_i) icache.valid |-> (outstanding_q != '0)
    );

endmodule

// File: tb/tb_riscv_fetch.sv
// -----------------------------------------------------------------------------
// tb_riscv_fetch
// Directed bench for riscv_fetch with default parameters (BOOT 0x100, depth 2,
// two outstanding reads). Each cycle drives the icache response and decode
// controls at the falling edge and compares the combinational outputs 1 ns
// later against hand-computed values. Instruction words are derived from
// their PC so a misplaced word is visible in opcode_o.
// -----------------------------------------------------------------------------
module tb_riscv_fetch;

`ifdef RISCV_FETCH_FAULT_EN
    localparam logic FAULT_EN = 1'b1;
`else
    localparam logic FAULT_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] opcode_o;
    logic [31:0] opcode_pc_o;
    logic        opcode_valid_o;
    logic        fault_fetch_o;
    logic        branch_i;
    logic [31:0] branch_pc_i;
    logic        stall_i;

    int passed = 0;
    int total  = 0;

    riscv_fetch_if icache ();

    riscv_fetch dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .icache         (icache),
        .opcode_o       (opcode_o),
        .opcode_pc_o    (opcode_pc_o),
        .opcode_valid_o (opcode_valid_o),
        .fault_fetch_o  (fault_fetch_o),
        .branch_i       (branch_i),
        .branch_pc_i    (branch_pc_i),
        .stall_i        (stall_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        acc;
        logic        vld;
        logic [31:0] rpc;    // PC whose word is returned when vld
        logic        stall;
        logic        e_rd;
        logic [31:0] e_ipc;
        logic        e_ov;
        logic [31:0] e_opc;  // checked only when e_ov
    } vec_t;

    function automatic logic [31:0] inst_for(input logic [31:0] pc);
        return {pc[23:0], 8'h13};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step(
        input string       tag,
        input logic        acc,
        input logic        vld,
        input logic [31:0] rpc,
        input logic        err,
        input logic        br,
        input logic [31:0] bpc,
        input logic        stl,
        input logic        e_rd,
        input logic [31:0] e_ipc,
        input logic        e_ov,
        input logic [31:0] e_opc,
        input logic        e_flt
    );
        @(negedge clk_i);
        icache.accept = acc;
        icache.valid  = vld;
        icache.inst   = vld ? inst_for(rpc) : 32'h0;
        icache.error  = err;
        branch_i      = br;
        branch_pc_i   = bpc;
        stall_i       = stl;
        #1;
        check({tag, " rd"},    {31'b0, icache.rd},      {31'b0, e_rd});
        check({tag, " ipc"},   icache.pc,               e_ipc);
        check({tag, " valid"}, {31'b0, opcode_valid_o}, {31'b0, e_ov});
        check({tag, " fault"}, {31'b0, fault_fetch_o},  {31'b0, e_flt});
        if (e_ov) begin
            check({tag, " opc_pc"}, opcode_pc_o, e_opc);
            check({tag, " opcode"}, opcode_o,    inst_for(e_opc));
        end
    endtask

    vec_t vecs [20];

    initial begin
        // Streaming with 1-cycle responses, a 5-cycle stall and accept held low.
        vecs[0]  = '{1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 32'h100, 1'b0, 32'h000};
        vecs[1]  = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h104, 1'b0, 32'h000};
        vecs[2]  = '{1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 32'h108, 1'b1, 32'h100};
        vecs[3]  = '{1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 32'h108, 1'b1, 32'h104};
        vecs[4]  = '{1'b1, 1'b1, 32'h108, 1'b0, 1'b1, 32'h10c, 1'b0, 32'h000};
        vecs[5]  = '{1'b1, 1'b1, 32'h10c, 1'b0, 1'b0, 32'h110, 1'b1, 32'h108};
        vecs[6]  = '{1'b1, 1'b0, 32'h000, 1'b1, 1'b1, 32'h110, 1'b1, 32'h10c};
        vecs[7]  = '{1'b1, 1'b1, 32'h110, 1'b1, 1'b0, 32'h114, 1'b1, 32'h10c};
        vecs[8]  = '{1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 32'h114, 1'b1, 32'h10c};
        vecs[9]  = '{1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 32'h114, 1'b1, 32'h10c};
        vecs[10] = '{1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 32'h114, 1'b1, 32'h10c};
        vecs[11] = '{1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h114, 1'b1, 32'h10c};
        vecs[12] = '{1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 32'h114, 1'b1, 32'h110};
        vecs[13] = '{1'b0, 1'b1, 32'h114, 1'b0, 1'b1, 32'h118, 1'b0, 32'h000};
        vecs[14] = '{1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 32'h118, 1'b1, 32'h114};
        vecs[15] = '{1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 32'h118, 1'b1, 32'h114};
        vecs[16] = '{1'b1, 1'b0, 32'h000, 1'b1, 1'b1, 32'h118, 1'b1, 32'h114};
        vecs[17] = '{1'b1, 1'b1, 32'h118, 1'b0, 1'b0, 32'h11c, 1'b1, 32'h114};
        vecs[18] = '{1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 32'h11c, 1'b1, 32'h118};
        vecs[19] = '{1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 32'h11c, 1'b0, 32'h000};

        icache.accept = 1'b0;
        icache.valid  = 1'b0;
        icache.inst   = 32'h0;
        icache.error  = 1'b0;
        branch_i      = 1'b0;
        branch_pc_i   = 32'h0;
        stall_i       = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk_i);
        #1;
        check("reset rd",     {31'b0, icache.rd},      32'h0);
        check("reset valid",  {31'b0, opcode_valid_o}, 32'h0);
        check("reset fault",  {31'b0, fault_fetch_o},  32'h0);
        check("reset opcode", opcode_o,                32'h0);
        check("reset opc_pc", opcode_pc_o,             32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step($sformatf("vec%0d", i), vecs[i].acc, vecs[i].vld, vecs[i].rpc, 1'b0,
                 1'b0, 32'h0, vecs[i].stall,
                 vecs[i].e_rd, vecs[i].e_ipc, vecs[i].e_ov, vecs[i].e_opc, 1'b0);
        end

        // Branch to 0x2002 with two reads outstanding, one returning that cycle.
        step("br_a", 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h11c,  1'b0, 32'h0,    1'b0);
        step("br_b", 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h120,  1'b0, 32'h0,    1'b0);
        step("br_c", 1'b1, 1'b1, 32'h11c, 1'b0, 1'b1, 32'h2002, 1'b0, 1'b0, 32'h124,  1'b0, 32'h0,    1'b0);
        step("br_d", 1'b1, 1'b1, 32'h120, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h2000, 1'b0, 32'h0,    1'b0);
        step("br_e", 1'b1, 1'b1, 32'h2000,1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h2004, 1'b0, 32'h0,    1'b0);
        step("br_f", 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h2008, 1'b1, 32'h2000, 1'b0);
        step("br_g", 1'b0, 1'b1, 32'h2004,1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h2008, 1'b1, 32'h2000, 1'b0);
        step("br_h", 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h2008, 1'b1, 32'h2004, 1'b0);

        // Back-to-back branches 0x400 then 0x800 with a buffered word and a
        // stale response in the second branch cycle.
        step("bb_i", 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h2008, 1'b0, 32'h0,    1'b0);
        step("bb_j", 1'b1, 1'b1, 32'h2008,1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h200c, 1'b0, 32'h0,    1'b0);
        step("bb_k", 1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 32'h400,  1'b0, 1'b0, 32'h2010, 1'b0, 32'h0,    1'b0);
        step("bb_l", 1'b1, 1'b1, 32'h200c,1'b0, 1'b1, 32'h800,  1'b0, 1'b0, 32'h400,  1'b0, 32'h0,    1'b0);
        step("bb_m", 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h800,  1'b0, 32'h0,    1'b0);
        step("bb_n", 1'b1, 1'b1, 32'h800, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h804,  1'b0, 32'h0,    1'b0);
        step("bb_o", 1'b0, 1'b1, 32'h804, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h808,  1'b1, 32'h800,  1'b0);
        step("bb_p", 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h808,  1'b1, 32'h804,  1'b0);

        // PC wrap at 0xFFFFFFFC, bus error on the wrapping word.
        step("wr_q", 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h808,       1'b0, 32'h0,         1'b0);
        step("wr_r", 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0);
        step("wr_s", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0);
        step("wr_t", 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, FAULT_EN);
        step("wr_u", 1'b0, 1'b1, 32'h000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         1'b0, 32'h0,         1'b0);
        step("wr_v", 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         1'b1, 32'h0,         1'b0);

        // Reset asserted mid-transaction with a buffered word and a stall.
        step("rs_w", 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h4,    1'b0, 32'h0,    1'b0);
        step("rs_x", 1'b0, 1'b1, 32'h004, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h8,    1'b0, 32'h0,    1'b0);
        step("rs_y", 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h8,    1'b1, 32'h4,    1'b0);
        rst_i = 1'b0;
        #1;
        check("midrst rd",     {31'b0, icache.rd},      32'h0);
        check("midrst valid",  {31'b0, opcode_valid_o}, 32'h0);
        check("midrst opc_pc", opcode_pc_o,             32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        step("rs_z", 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h100,  1'b0, 32'h0,    1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
